// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand sequencer: select codes, FSM states and
// the default data width.
package alu_pkg;

  localparam int unsigned DEF_WIDTH = 4;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;
  localparam logic [2:0] ALU_GT  = 3'b110;
  localparam logic [2:0] ALU_EQ  = 3'b111;

  typedef enum logic [1:0] {IDLE, ISSUE, WRITEBACK} state_e;

  // Only add and sub produce a meaningful carry/borrow out of the ALU.
  function automatic logic op_has_carry(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Small register file: async clear, one write port, two operand reads and one
// debug read, all reads combinational.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NREGS = 4,
  parameter int unsigned AW    = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_a_i,
  output logic [WIDTH-1:0] rdata_a_o,
  input  logic [AW-1:0]    raddr_b_i,
  output logic [WIDTH-1:0] rdata_b_o,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we_i) begin
      regs_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];
  assign rd_data_o = regs_q[rd_addr_i];

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator for an external combinational ALU: accepts one command at a time,
// drives operands from the register file and writes the result back with flags.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NREGS = 4,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [2:0]       cmd_op,
  input  logic [AW-1:0]    cmd_src_a,
  input  logic [AW-1:0]    cmd_src_b,
  input  logic [AW-1:0]    cmd_dst,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  output logic             done,
  output logic             flag_zero,
  output logic             flag_carry,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [AW-1:0]    dst_q, dst_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             flag_zero_q, flag_zero_d;
  logic             flag_carry_q, flag_carry_d;

  logic             accept;
  logic             rf_we;
  logic [AW-1:0]    rf_waddr;
  logic [WIDTH-1:0] rf_wdata;
  logic [WIDTH-1:0] rf_rdata_a;
  logic [WIDTH-1:0] rf_rdata_b;

  alu_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_regfile (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (cmd_src_a),
    .rdata_a_o (rf_rdata_a),
    .raddr_b_i (cmd_src_b),
    .rdata_b_o (rf_rdata_b),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  // Gating with rst keeps ready low for the whole reset, not just after an edge.
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    dst_d        = dst_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    flag_zero_d  = flag_zero_q;
    flag_carry_d = flag_carry_q;
    rf_we        = 1'b0;
    rf_waddr     = dst_q;
    rf_wdata     = alu_result;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          dst_d = cmd_dst;
          if (cmd_load) begin
            rf_we        = 1'b1;
            rf_waddr     = cmd_dst;
            rf_wdata     = cmd_imm;
            flag_zero_d  = (cmd_imm == '0);
            flag_carry_d = 1'b0;
            state_d      = WRITEBACK;
          end else begin
            // No write can land before ISSUE, so these equal the ISSUE-time reads.
            op_d    = cmd_op;
            alu_a_d = rf_rdata_a;
            alu_b_d = rf_rdata_b;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        rf_we        = 1'b1;
        flag_zero_d  = (alu_result == '0);
        flag_carry_d = alu_carry && op_has_carry(op_q);
        state_d      = WRITEBACK;
      end
      WRITEBACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= '0;
      dst_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      flag_zero_q  <= 1'b0;
      flag_carry_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      dst_q        <= dst_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      flag_zero_q  <= flag_zero_d;
      flag_carry_q <= flag_carry_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = op_q;
  assign done       = (state_q == WRITEBACK);
  assign flag_zero  = flag_zero_q;
  assign flag_carry = flag_carry_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 4-bit ALU attached.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [2:0] cmd_op;
  logic [1:0] cmd_src_a, cmd_src_b, cmd_dst;
  logic [3:0] cmd_imm;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_sel;
  logic [3:0] alu_result;
  logic       alu_carry;
  logic       done, flag_zero, flag_carry;
  logic [1:0] rd_addr;
  logic [3:0] rd_data;
  logic [4:0] alu_r;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .WIDTH (4),
    .NREGS (4),
    .AW    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_load   (cmd_load),
    .cmd_op     (cmd_op),
    .cmd_src_a  (cmd_src_a),
    .cmd_src_b  (cmd_src_b),
    .cmd_dst    (cmd_dst),
    .cmd_imm    (cmd_imm),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .done       (done),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  // External combinational ALU; bit 4 is the internal carry/borrow bit.
  always_comb begin
    alu_r = '0;
    case (alu_sel)
      ALU_ADD: alu_r = {1'b0, alu_a} + {1'b0, alu_b};
      ALU_SUB: alu_r = {1'b0, alu_a} - {1'b0, alu_b};
      ALU_AND: alu_r = {1'b0, alu_a & alu_b};
      ALU_OR:  alu_r = {1'b0, alu_a | alu_b};
      ALU_XOR: alu_r = {1'b0, alu_a ^ alu_b};
      ALU_NOT: alu_r = ~{1'b0, alu_a};
      ALU_GT:  alu_r = {4'b0000, alu_a > alu_b};
      default: alu_r = {4'b0000, alu_a == alu_b};
    endcase
  end
  assign alu_result = alu_r[3:0];
  assign alu_carry  = alu_r[4];

  task automatic put_cmd(input logic ld, input logic [2:0] op, input logic [1:0] sa,
                         input logic [1:0] sb, input logic [1:0] dst, input logic [3:0] imm);
    cmd_load  = ld;
    cmd_op    = op;
    cmd_src_a = sa;
    cmd_src_b = sb;
    cmd_dst   = dst;
    cmd_imm   = imm;
    cmd_valid = 1'b1;
  endtask

  // Called at a negedge; returns just after the accepting posedge.
  task automatic accept(input logic ld, input logic [2:0] op, input logic [1:0] sa,
                        input logic [1:0] sb, input logic [1:0] dst, input logic [3:0] imm);
    int n;
    n = 0;
    put_cmd(ld, op, sa, sb, dst, imm);
    #1;
    while (!cmd_ready && n < 16) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic load_reg(input logic [1:0] dst, input logic [3:0] imm);
    accept(1'b1, ALU_ADD, 2'd0, 2'd0, dst, imm);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cmd_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks += 7;
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b want 0", cmd_ready); end
    if (alu_a !== 4'h0) begin failures++; $display("FAIL rst_alu_a: got %b want 0000", alu_a); end
    if (alu_b !== 4'h0) begin failures++; $display("FAIL rst_alu_b: got %b want 0000", alu_b); end
    if (alu_sel !== 3'b000) begin failures++; $display("FAIL rst_alu_sel: got %b want 000", alu_sel); end
    if (done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b want 0", done); end
    if (flag_zero !== 1'b0) begin failures++; $display("FAIL rst_zero: got %b want 0", flag_zero); end
    if (flag_carry !== 1'b0) begin failures++; $display("FAIL rst_carry: got %b want 0", flag_carry); end
    cmd_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready: got %b want 1", cmd_ready); end
    @(negedge clk);
  endtask

  task automatic test_add;
    load_reg(2'd0, 4'b1101);
    load_reg(2'd1, 4'b1011);
    accept(1'b0, ALU_ADD, 2'd0, 2'd1, 2'd2, 4'h0);
    @(negedge clk);
    checks += 5;
    if (alu_a !== 4'b1101) begin failures++; $display("FAIL add_alu_a: got %b want 1101", alu_a); end
    if (alu_b !== 4'b1011) begin failures++; $display("FAIL add_alu_b: got %b want 1011", alu_b); end
    if (alu_sel !== 3'b000) begin failures++; $display("FAIL add_alu_sel: got %b want 000", alu_sel); end
    if (done !== 1'b0) begin failures++; $display("FAIL add_done_early: got %b want 0", done); end
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL add_ready_issue: got %b want 0", cmd_ready); end
    @(negedge clk);
    rd_addr = 2'd2;
    #1;
    checks += 5;
    if (done !== 1'b1) begin failures++; $display("FAIL add_done: got %b want 1", done); end
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL add_ready_wb: got %b want 0", cmd_ready); end
    if (rd_data !== 4'b1000) begin failures++; $display("FAIL add_r2: got %b want 1000", rd_data); end
    if (flag_carry !== 1'b1) begin failures++; $display("FAIL add_carry: got %b want 1", flag_carry); end
    if (flag_zero !== 1'b0) begin failures++; $display("FAIL add_zero: got %b want 0", flag_zero); end
    @(negedge clk);
    checks += 2;
    if (done !== 1'b0) begin failures++; $display("FAIL add_done_pulse: got %b want 0", done); end
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL add_ready_idle: got %b want 1", cmd_ready); end
  endtask

  task automatic test_sub_gt;
    load_reg(2'd0, 4'b0011);
    load_reg(2'd1, 4'b1011);
    accept(1'b0, ALU_SUB, 2'd0, 2'd1, 2'd3, 4'h0);
    repeat (2) @(negedge clk);
    rd_addr = 2'd3;
    #1;
    checks += 3;
    if (rd_data !== 4'b1000) begin failures++; $display("FAIL sub_r3: got %b want 1000", rd_data); end
    if (flag_carry !== 1'b1) begin failures++; $display("FAIL sub_borrow: got %b want 1", flag_carry); end
    if (flag_zero !== 1'b0) begin failures++; $display("FAIL sub_zero: got %b want 0", flag_zero); end
    @(negedge clk);
    accept(1'b0, ALU_GT, 2'd0, 2'd1, 2'd3, 4'h0);
    repeat (2) @(negedge clk);
    #1;
    checks += 3;
    if (rd_data !== 4'b0000) begin failures++; $display("FAIL gt_r3: got %b want 0000", rd_data); end
    if (flag_zero !== 1'b1) begin failures++; $display("FAIL gt_zero: got %b want 1", flag_zero); end
    if (flag_carry !== 1'b0) begin failures++; $display("FAIL gt_carry: got %b want 0", flag_carry); end
    @(negedge clk);
  endtask

  task automatic test_not_overlap;
    load_reg(2'd0, 4'b1100);
    accept(1'b0, ALU_NOT, 2'd0, 2'd0, 2'd0, 4'h0);
    @(negedge clk);
    checks += 2;
    if (alu_a !== 4'b1100) begin failures++; $display("FAIL not_alu_a: got %b want 1100", alu_a); end
    if (alu_sel !== 3'b101) begin failures++; $display("FAIL not_alu_sel: got %b want 101", alu_sel); end
    @(negedge clk);
    rd_addr = 2'd0;
    #1;
    checks += 3;
    if (rd_data !== 4'b0011) begin failures++; $display("FAIL not_r0: got %b want 0011", rd_data); end
    if (flag_carry !== 1'b0) begin failures++; $display("FAIL not_carry: got %b want 0", flag_carry); end
    if (flag_zero !== 1'b0) begin failures++; $display("FAIL not_zero: got %b want 0", flag_zero); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int n_acc, n_done, n_both;
    n_acc = 0;
    n_done = 0;
    n_both = 0;
    load_reg(2'd1, 4'b0001);
    load_reg(2'd2, 4'b0000);
    // R2 += R1 repeatedly; any dropped or duplicated accept changes the final R2.
    put_cmd(1'b0, ALU_ADD, 2'd2, 2'd1, 2'd2, 4'h0);
    for (int k = 0; k < 12; k++) begin
      #1;
      if (cmd_ready) n_acc++;
      if (done) n_done++;
      if (cmd_ready && done) n_both++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    rd_addr = 2'd2;
    #1;
    checks += 4;
    if (n_acc != 4) begin failures++; $display("FAIL b2b_accepts: got %0d want 4", n_acc); end
    if (n_done != 4) begin failures++; $display("FAIL b2b_dones: got %0d want 4", n_done); end
    if (n_both != 0) begin failures++; $display("FAIL b2b_ready_in_wb: got %0d want 0", n_both); end
    if (rd_data !== 4'b0100) begin failures++; $display("FAIL b2b_r2: got %b want 0100", rd_data); end
  endtask

  task automatic test_reset_mid;
    int n_nonzero;
    n_nonzero = 0;
    load_reg(2'd0, 4'b0111);
    load_reg(2'd3, 4'b0000);
    accept(1'b0, ALU_ADD, 2'd0, 2'd0, 2'd1, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks += 2;
    if (done !== 1'b0) begin failures++; $display("FAIL midrst_done: got %b want 0", done); end
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL midrst_ready: got %b want 0", cmd_ready); end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rd_addr = i[1:0];
      #1;
      if (rd_data !== 4'h0) n_nonzero++;
    end
    checks += 4;
    if (done !== 1'b0) begin failures++; $display("FAIL midrst_done2: got %b want 0", done); end
    if (n_nonzero != 0) begin failures++; $display("FAIL midrst_regs: got %0d nonzero want 0", n_nonzero); end
    if (flag_zero !== 1'b0) begin failures++; $display("FAIL midrst_zero: got %b want 0", flag_zero); end
    if (flag_carry !== 1'b0) begin failures++; $display("FAIL midrst_carry: got %b want 0", flag_carry); end
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL midrst_release: got %b want 1", cmd_ready); end
    @(negedge clk);
    rd_addr = 2'd1;
    #1;
    checks += 2;
    if (done !== 1'b0) begin failures++; $display("FAIL midrst_late_done: got %b want 0", done); end
    if (rd_data !== 4'h0) begin failures++; $display("FAIL midrst_r1: got %b want 0000", rd_data); end
  endtask

  task automatic test_load_zero;
    load_reg(2'd0, 4'b1111);
    load_reg(2'd1, 4'b0001);
    accept(1'b0, ALU_ADD, 2'd0, 2'd1, 2'd2, 4'h0);
    repeat (2) @(negedge clk);
    checks++;
    if (flag_carry !== 1'b1) begin failures++; $display("FAIL lz_pre_carry: got %b want 1", flag_carry); end
    @(negedge clk);
    accept(1'b1, ALU_ADD, 2'd0, 2'd0, 2'd1, 4'b0000);
    @(negedge clk);
    rd_addr = 2'd1;
    #1;
    checks += 4;
    if (done !== 1'b1) begin failures++; $display("FAIL lz_done: got %b want 1", done); end
    if (flag_zero !== 1'b1) begin failures++; $display("FAIL lz_zero: got %b want 1", flag_zero); end
    if (flag_carry !== 1'b0) begin failures++; $display("FAIL lz_carry: got %b want 0", flag_carry); end
    if (rd_data !== 4'b0000) begin failures++; $display("FAIL lz_r1: got %b want 0000", rd_data); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL lz_done_pulse: got %b want 0", done); end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_load  = 1'b0;
    cmd_op    = 3'b000;
    cmd_src_a = 2'd0;
    cmd_src_b = 2'd0;
    cmd_dst   = 2'd0;
    cmd_imm   = 4'h0;
    rd_addr   = 2'd0;
    @(negedge clk);
    test_reset();
    test_add();
    test_sub_gt();
    test_not_overlap();
    test_back_to_back();
    test_reset_mid();
    test_load_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator side of the ALU operand/select interface. Accepts one command at a time over a valid/ready handshake.
- Holds a small register file. Reads two source registers and drives them with an opcode onto the ALU's A/B/sel inputs.
- Captures the ALU result and carry, writes the result back to a destination register, and keeps zero/carry status flags.
- Sits between a test driver or control unit and the existing combinational 4-bit ALU. That ALU stays outside this block.

Parameters:
- WIDTH, 4: data width of registers, operands and ALU result.
- NREGS, 4: number of registers in the register file (power of two).
- AW, 2: register address width, equal to log2(NREGS).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_load  input  1  1 = load immediate into the destination, bypassing the ALU.
- cmd_op  input  3  ALU select code (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not A, 110 A>B, 111 A==B).
- cmd_src_a  input  AW  register index for operand A.
- cmd_src_b  input  AW  register index for operand B.
- cmd_dst  input  AW  destination register index.
- cmd_imm  input  WIDTH  immediate value used when cmd_load=1.
- alu_a  output  WIDTH  operand A to the ALU.
- alu_b  output  WIDTH  operand B to the ALU.
- alu_sel  output  3  select code to the ALU.
- alu_result  input  WIDTH  ALU result, lower bits.
- alu_carry  input  1  ALU carry/borrow, bit WIDTH of the internal sum.
- done  output  1  one-cycle pulse: writeback complete.
- flag_zero  output  1  last written value was zero.
- flag_carry  output  1  carry/borrow of the last add or sub.
- rd_addr  input  AW  debug read address.
- rd_data  output  WIDTH  combinational read of reg[rd_addr].

Behaviour:
- Reset (async, rst=1):
  - All registers become 0 and the state becomes IDLE.
  - cmd_ready=0 while rst is high and 1 from the first cycle after release.
  - alu_a, alu_b, alu_sel, done, flag_zero and flag_carry are 0.
- States: IDLE, ISSUE, WRITEBACK.
- IDLE:
  - cmd_ready=1. The handshake completes on a clk edge with cmd_valid&&cmd_ready.
  - On that edge the whole command is latched.
  - cmd_load=1: go to WRITEBACK with the capture value = cmd_imm.
  - cmd_load=0: go to ISSUE.
- ISSUE (exactly one cycle):
  - cmd_ready=0. alu_a=reg[src_a], alu_b=reg[src_b] and alu_sel=op, all from registered state, stable for the whole cycle.
  - The ALU is combinational, so alu_result and alu_carry are sampled at the end of ISSUE.
  - On that edge: reg[dst] ← alu_result.
  - flag_zero ← (alu_result==0).
  - flag_carry ← alu_carry if op is 000 or 001, else 0. The ALU's bit WIDTH is meaningless for other ops.
- Load path:
  - At the end of the IDLE accept cycle: reg[dst] ← cmd_imm, flag_zero ← (cmd_imm==0), flag_carry ← 0.
- WRITEBACK (one cycle):
  - done=1, cmd_ready=0. The updated register and flags are visible. The next state is IDLE.
- ALU outputs outside ISSUE: alu_a, alu_b and alu_sel hold their last values; they are only meaningful during ISSUE.
- Latency:
  - ALU op: accept at edge N, done high in cycle N+2, next accept possible at edge N+3.
  - Load: done high in cycle N+1.
- Operand/destination overlap: dst equal to src_a or src_b is legal. Sources are read in ISSUE, before the write.
- Backpressure: cmd_valid held while busy is ignored until IDLE; nothing is dropped or duplicated. cmd_* may change freely while cmd_ready=0.
- Reset mid-operation: abort immediately, no writeback, no done pulse; the register file and flags clear.
- Arithmetic:
  - Wrap-around is modulo 2^WIDTH, as supplied by the ALU. This block does no arithmetic of its own.
  - Subtraction borrow shows as flag_carry=1.

Decomposition:
- Shared package alu_pkg:
  - ALU select constants (ALU_ADD=3'b000 … ALU_EQ=3'b111).
  - State enum typedef {IDLE, ISSUE, WRITEBACK}.
  - Default WIDTH.
- One natural sub-module: alu_regfile. It has NREGS×WIDTH storage with async clear, one write port, two combinational operand reads and one combinational debug read.
- The FSM and flags stay in the top.

Test Plan:
- Load R0=1101, R1=1011, then op 000 src 0,1 dst 2. Required: alu_a=1101, alu_b=1011, alu_sel=000 in ISSUE; R2=1000, flag_carry=1, flag_zero=0; done exactly 2 cycles after accept.
- Load R0=0011, R1=1011, then op 001 dst 3. Required: R3=1000, flag_carry=1 (borrow). Then op 110 dst 3: R3=0000, flag_zero=1, flag_carry=0.
- Load R0=1100, then op 101 src_a 0 dst 0 (dst overlaps src). Required: R0=0011, flag_carry=0 even though alu_carry=1.
- Hold cmd_valid high across back-to-back commands. Required: cmd_ready=0 in ISSUE/WRITEBACK, exactly one accept per IDLE, done count equals command count.
- Assert rst during ISSUE. Required: no done pulse, all registers read 0 via rd_data, flags 0, cmd_ready=1 one cycle after release.
- Load immediate 0000 into R1. Required: done the next cycle, flag_zero=1, flag_carry=0, rd_addr=1 gives rd_data=0000.
